// File: rtl/hdc_pkg.sv
// Shared HDC encoding constants and sizing helpers for the window encoder and its per-dimension counters.
package hdc_pkg;

  localparam logic OP_TRAIN   = 1'b0;
  localparam logic OP_PREDICT = 1'b1;
  localparam logic LABEL_NS   = 1'b0;
  localparam logic LABEL_S    = 1'b1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  // Counter must hold 0..window inclusive.
  function automatic int cnt_width(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/dim_majority_counter.sv
// One dimension of the bundler: counts ones over a window and votes on the post-increment count.
// Zero-cycle vote (combinational from current count + increment); no backpressure.
module dim_majority_counter
  import hdc_pkg::*;
#(
  parameter int WINDOW = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic inc_i,
  input  logic clr_i,
  input  logic tie_i,
  output logic maj_o
);

  localparam int CW = cnt_width(WINDOW);
  localparam logic [CW:0] WIN_L = (CW+1)'(WINDOW);

  logic [CW-1:0] cnt_q, cnt_d, cnt_post;
  logic [CW:0]   dbl;

  assign cnt_post = cnt_q + CW'(inc_i);
  assign cnt_d    = clr_i ? '0 : cnt_post;

  // Compare 2*c against WINDOW so odd and even windows share one rule.
  assign dbl   = {cnt_post, 1'b0};
  assign maj_o = (dbl > WIN_L) ? 1'b1 : ((dbl < WIN_L) ? 1'b0 : tie_i);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hv_window_encoder.sv
// Bundles WINDOW sample hypervectors by per-dimension majority and emits one with a single-cycle out_en.
// out_en follows the final sample's edge by one cycle; accepts one sample per cycle, never stalls.
module hv_window_encoder
  import hdc_pkg::*;
#(
  parameter int                    DIMENSIONS = 10000,
  parameter int                    WINDOW     = 4,
  parameter logic [DIMENSIONS-1:0] TIE_HV     = '0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  in_valid,
  input  logic [DIMENSIONS-1:0] in_hv,
  input  logic                  in_op,
  input  logic                  in_label,
  input  logic                  flush,
  output logic                  out_en,
  output logic [DIMENSIONS-1:0] out_hv,
  output logic                  out_op,
  output logic                  out_label,
  output logic                  busy
);

  localparam int SW = cnt_width(WINDOW);

  logic [0:0]            state_q, state_d;
  logic [SW-1:0]         scnt_q, scnt_d;
  logic                  wop_q, wop_d, wlab_q, wlab_d;
  logic                  en_q, en_d, op_q, op_d, lab_q, lab_d;
  logic [DIMENSIONS-1:0] hv_q, hv_d;
  logic [DIMENSIONS-1:0] maj;
  logic                  accept, last, clr;

  assign accept = in_valid & ~flush;
  assign last   = accept && (scnt_q == SW'(WINDOW - 1));
  assign clr    = flush | last;

  for (genvar g = 0; g < DIMENSIONS; g++) begin : g_dim
    dim_majority_counter #(.WINDOW(WINDOW)) u_cnt (
      .clk  (clk),
      .nrst (nrst),
      .inc_i(accept & in_hv[g]),
      .clr_i(clr),
      .tie_i(TIE_HV[g]),
      .maj_o(maj[g])
    );
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    wop_d   = wop_q;
    wlab_d  = wlab_q;
    en_d    = 1'b0;
    hv_d    = hv_q;
    op_d    = op_q;
    lab_d   = lab_q;
    if (flush) begin
      state_d = ST_IDLE;
      scnt_d  = '0;
    end else if (accept) begin
      if (state_q == ST_IDLE) begin
        wop_d  = in_op;
        wlab_d = in_label;
      end
      if (last) begin
        state_d = ST_IDLE;
        scnt_d  = '0;
        en_d    = 1'b1;
        hv_d    = maj;
        // A one-sample window must take op/label straight from the inputs.
        op_d    = (state_q == ST_IDLE) ? in_op : wop_q;
        lab_d   = (state_q == ST_IDLE) ? in_label : wlab_q;
      end else begin
        state_d = ST_ACCUM;
        scnt_d  = scnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      scnt_q  <= '0;
      wop_q   <= OP_TRAIN;
      wlab_q  <= LABEL_NS;
      en_q    <= 1'b0;
      hv_q    <= '0;
      op_q    <= OP_TRAIN;
      lab_q   <= LABEL_NS;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      wop_q   <= wop_d;
      wlab_q  <= wlab_d;
      en_q    <= en_d;
      hv_q    <= hv_d;
      op_q    <= op_d;
      lab_q   <= lab_d;
    end
  end

  assign out_en    = en_q;
  assign out_hv    = hv_q;
  assign out_op    = op_q;
  assign out_label = lab_q;
  assign busy      = (state_q == ST_ACCUM);

endmodule
